drp_channel_responder: RTL

//  DRP slave matching the XADC Wizard port protocol (den/dwe/daddr/di -> do/drdy).

---
 rtl/drp_pkg.sv | 17 +
 rtl/drp_result_bank.sv | 44 ++++
 rtl/drp_channel_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/drp_pkg.sv
// Shared DRP constants and FSM state encodings for the channel responder.
package drp_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    // Both windows start on a 16-address boundary so decode can use the upper address bits.
    localparam logic [DRP_ADDR_W-1:0] AUX_BASE = 7'h10;
    localparam logic [DRP_ADDR_W-1:0] CFG_BASE = 7'h40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } drp_state_e;

endpackage

// File: rtl/drp_result_bank.sv
// 16 x 16-bit aux result registers: one sample write port, one registered read port.
module drp_result_bank
    import drp_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [3:0]            wr_idx,
    input  logic [DRP_DATA_W-1:0] wr_data,
    input  logic [3:0]            rd_idx,
    output logic [DRP_DATA_W-1:0] rd_data
);

    logic [DRP_DATA_W-1:0] mem_q [16];
    logic [DRP_DATA_W-1:0] mem_d [16];
    logic [DRP_DATA_W-1:0] rd_q;
    logic [DRP_DATA_W-1:0] rd_d;

    // Apply the sample write; the read register tracks the post-write contents, so whatever it
    // holds during a cycle ignores a write landing in that same cycle (old value until the next edge).
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
        rd_d = mem_d[rd_idx];
    end

    // Storage and read register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/drp_channel_responder.sv
// DRP slave exposing aux filter results and a small config bank with XADC-like timing.
//
// state   | meaning
// IDLE    | waiting for den; request fields latched on den
// WAIT    | latency countdown running
// ACK     | drdy pulse, read data driven, config write commits
module drp_channel_responder
    import drp_pkg::*;
#(
    parameter int                    RD_LATENCY = 4,
    parameter int                    NUM_CFG    = 8,
    parameter logic [DRP_DATA_W-1:0] CFG_RESET  = 16'h0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          den,
    input  logic                          dwe,
    input  logic [DRP_ADDR_W-1:0]         daddr,
    input  logic [DRP_DATA_W-1:0]         di,
    output logic [DRP_DATA_W-1:0]         do_out,
    output logic                          drdy,
    output logic                          busy,
    input  logic                          sample_valid,
    input  logic [3:0]                    sample_ch,
    input  logic [DRP_DATA_W-1:0]         sample_data,
    output logic                          eoc,
    output logic [4:0]                    channel,
    output logic [DRP_DATA_W*NUM_CFG-1:0] cfg_flat,
    output logic                          err_overlap
);

    localparam logic [3:0] LAT_M1    = 4'(RD_LATENCY - 1);
    localparam logic [4:0] NUM_CFG_W = 5'(NUM_CFG);

    drp_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DRP_ADDR_W-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [DRP_DATA_W-1:0] wdata_q, wdata_d;
    logic [DRP_DATA_W-1:0] cfg_q [NUM_CFG];
    logic [DRP_DATA_W-1:0] cfg_d [NUM_CFG];
    logic                  err_q, err_d;
    logic                  eoc_q, eoc_d;
    logic [4:0]            channel_q, channel_d;

    logic                  addr_is_aux;
    logic                  addr_is_cfg;
    logic [DRP_DATA_W-1:0] cfg_rd;
    logic [DRP_DATA_W-1:0] aux_rd;
    logic [3:0]            rd_idx;

    // In IDLE the bank is pointed at the incoming address so RD_LATENCY=1 still sees the right channel.
    assign rd_idx = (state_q == ST_IDLE) ? daddr[3:0] : addr_q[3:0];

    drp_result_bank u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (sample_valid),
        .wr_idx  (sample_ch),
        .wr_data (sample_data),
        .rd_idx  (rd_idx),
        .rd_data (aux_rd)
    );

    // Address decode of the latched request.
    always_comb begin
        addr_is_aux = (addr_q[6:4] == AUX_BASE[6:4]);
        addr_is_cfg = (addr_q[6:4] == CFG_BASE[6:4]) && ({1'b0, addr_q[3:0]} < NUM_CFG_W);
        cfg_rd      = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (addr_q[3:0] == 4'(i)) begin
                cfg_rd = cfg_q[i];
            end
        end
    end

    // Next-state logic: request capture and latency countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (den) begin
                    addr_d  = daddr;
                    wr_d    = dwe;
                    wdata_d = di;
                    cnt_d   = LAT_M1;
                    state_d = (RD_LATENCY == 1) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Config commit, overlap flag and sample-side event pulse.
    always_comb begin
        cfg_d = cfg_q;
        if ((state_q == ST_ACK) && wr_q && addr_is_cfg) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (addr_q[3:0] == 4'(i)) begin
                    cfg_d[i] = wdata_q;
                end
            end
        end
        err_d     = err_q | (den && (state_q != ST_IDLE));
        eoc_d     = sample_valid;
        channel_d = sample_valid ? {1'b1, sample_ch} : channel_q;
    end

    // Output logic: drdy and read data exist only in ACK.
    always_comb begin
        drdy   = 1'b0;
        do_out = '0;
        busy   = (state_q != ST_IDLE);
        if (state_q == ST_ACK) begin
            drdy = 1'b1;
            if (!wr_q) begin
                if (addr_is_aux) begin
                    do_out = aux_rd;
                end else if (addr_is_cfg) begin
                    do_out = cfg_rd;
                end
            end
        end
    end

    // Flatten the config bank, register 0 in the LSBs.
    always_comb begin
        cfg_flat = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            cfg_flat[i*DRP_DATA_W +: DRP_DATA_W] = cfg_q[i];
        end
    end

    // State register and all control flops; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_q[i] <= CFG_RESET;
            end
            err_q     <= 1'b0;
            eoc_q     <= 1'b0;
            channel_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            cfg_q     <= cfg_d;
            err_q     <= err_d;
            eoc_q     <= eoc_d;
            channel_q <= channel_d;
        end
    end

    assign eoc         = eoc_q;
    assign channel     = channel_q;
    assign err_overlap = err_q;

endmodule
